aux_freq_meter: RTL

Measurement front-end for the low-frequency tracking loop that sits directly downstream of the auxiliary ring oscillator. It drives the oscillator's global enable, waits a programmable settling time, then counts rising edges of one oscillator phase over a programmable window of system clocks. It returns the count through a valid/ready handshake to the loop controller. One measurement runs per `start` request; the oscillator is powered only while a measurement is in progress.

---
 rtl/aux_freq_meter_if.sv | 24 ++
 rtl/aux_freq_meter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/aux_freq_meter_if.sv
// Result channel of the auxiliary frequency meter: edge count plus overflow,
// transferred with a valid/ready handshake.
interface aux_freq_meter_if #(
    parameter int CNT_W = 16
) ();
    logic             count_valid;
    logic             count_ready;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output count_valid,
        output count,
        output overflow,
        input  count_ready
    );

    modport slave (
        input  count_valid,
        input  count,
        input  overflow,
        output count_ready
    );
endinterface

// File: rtl/aux_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, waits a settle time,
// counts synchronized rising edges over a window and hands the count back.
module aux_freq_meter #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16,
    parameter int SET_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic [SET_W-1:0] settle_len,
    input  logic             osc_in,
    output logic             osc_en,
    output logic             busy,
    aux_freq_meter_if.master res
);

    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, HOLD} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] edges_q, edges_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             osc_en_q, osc_en_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             edge_det;
    logic [CNT_W:0]   bump;
    logic [CNT_W-1:0] meas_edges;
    logic             meas_ovf;

    // A programmed length of zero still runs one cycle.
    function automatic logic [TMR_W-1:0] at_least_one(input logic [TMR_W-1:0] v);
        return (v == '0) ? TMR_W'(1) : v;
    endfunction

    // Returns {attempted_past_max, saturated value + 1}.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return {1'b1, v};
        return {1'b0, v + CNT_W'(1)};
    endfunction

    // prev simply trails the synchronizer every cycle, so on the first window
    // cycle it already holds the last settle-cycle sample.
    assign edge_det = sync2_q & ~prev_q;

    always_comb begin
        state_d    = state_q;
        sync1_d    = osc_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        tmr_d      = tmr_q;
        win_d      = win_q;
        edges_d    = edges_q;
        ovf_acc_d  = ovf_acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        bump       = sat_inc(edges_q);
        meas_edges = edge_det ? bump[CNT_W-1:0] : edges_q;
        meas_ovf   = ovf_acc_q | (edge_det & bump[CNT_W]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETTLE;
                    tmr_d     = at_least_one(TMR_W'(settle_len));
                    win_d     = win_len;
                    edges_d   = '0;
                    ovf_acc_d = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tmr_q == TMR_W'(1)) begin
                    state_d = MEASURE;
                    tmr_d   = at_least_one(TMR_W'(win_q));
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            MEASURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    edges_d   = meas_edges;
                    ovf_acc_d = meas_ovf;
                    if (tmr_q == TMR_W'(1)) begin
                        state_d    = HOLD;
                        count_d    = meas_edges;
                        overflow_d = meas_ovf;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
            end
            HOLD: begin
                if (res.count_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies decoded from the next state.
        osc_en_d = (state_d == SETTLE) || (state_d == MEASURE);
        busy_d   = (state_d != IDLE);
        valid_d  = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            tmr_q      <= '0;
            win_q      <= '0;
            edges_q    <= '0;
            ovf_acc_q  <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            osc_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            tmr_q      <= tmr_d;
            win_q      <= win_d;
            edges_q    <= edges_d;
            ovf_acc_q  <= ovf_acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            osc_en_q   <= osc_en_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign osc_en          = osc_en_q;
    assign busy            = busy_q;
    assign res.count_valid = valid_q;
    assign res.count       = count_q;
    assign res.overflow    = overflow_q;

endmodule
